pixel_sensor_ctrl: RTL and testbench
====================================

Name: pixel_sensor_ctrl

Overview:
Synthesizable frame sequencer for PIXEL_ARRAY. Drives erase/expose/convert phases, the ADC digital ramp counter, the analog ramp/bias enables and one-hot row READ. Streams rows to the readout path with a valid/ready handshake. Sits between the top-level sensor interface and PIXEL_ARRAY, replacing the bench-side state machine.

Parameters:
HEIGHT, PixelSensorConfig::PIXEL_ARRAY_HEIGHT, number of rows (>=1)
BITS, PixelSensorConfig::PIXEL_BITS, ramp counter width
C_ERASE, 5, erase phase length in cycles (>=1)
C_CONVERT, 255, convert phase length in cycles (>=1, <=2**BITS-1)
C_READ_ROW, 5, cycles READ is held per row before row_valid (>=1)

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  asynchronous, active-low; clears all state
start  in  1  begin one frame; sampled only in IDLE
continuous  in  1  sampled at frame end; 1 = start next frame automatically
abort  in  1  synchronous; return to IDLE next cycle
expose_cycles  in  8  exposure length, latched on accepted start (0 treated as 1)
erase  out  1  PIXEL_ARRAY ERASE
expose  out  1  PIXEL_ARRAY EXPOSE
bias_en  out  1  gates bias toggling; equals expose
ramp_en  out  1  gates analog ramp; high during CONVERT
counter  out  BITS  digital ramp to PIXEL_ARRAY COUNTER
read  out  HEIGHT  one-hot row select
row_valid  out  1  current row data stable on DATA_OUT
row_index  out  $clog2(HEIGHT) (min 1)  row number qualifying row_valid
row_ready  in  1  consumer accepts row when row_valid & row_ready
frame_done  out  1  one-cycle pulse after last row accepted
busy  out  1  high in every state except IDLE

Behaviour:
- All outputs registered. Reset: state IDLE, all outputs 0, latched exposure 1.
- States: IDLE, ERASE, GAP, EXPOSE, CONVERT, READ. GAP = one cycle, all strobes low, between every pair of phases.
- IDLE: start=1 -> ERASE; erase high the cycle after start is sampled.
- ERASE: erase=1 for exactly C_ERASE cycles -> GAP -> EXPOSE.
- EXPOSE: expose=bias_en=1 for latched expose_cycles cycles -> GAP -> CONVERT.
- CONVERT: ramp_en=1 for C_CONVERT cycles; counter=0 on first cycle, +1 per cycle, ends at C_CONVERT-1; counter=0 outside CONVERT, no wrap. -> GAP -> READ.
- READ: row r from 0: read=1<<r for C_READ_ROW cycles, then row_valid=1, row_index=r, read held. Held until row_ready=1; on handshake cycle row_valid is still 1. Next cycle read=1<<(r+1), row_valid=0. No cycle with read=0 between rows.
- After row HEIGHT-1 handshake: read=0, frame_done=1 for one cycle. If continuous=1 on that cycle -> GAP -> ERASE (new expose_cycles latched there); else -> IDLE.
- row_ready before row_valid is ignored; row_ready held high gives row period C_READ_ROW+1 cycles.
- abort (any state except IDLE): next cycle IDLE, all outputs 0, no frame_done. abort has priority over start and over handshake on the same cycle.
- start while busy ignored. Reset mid-frame: immediate return to reset values.
- At most one of erase/expose/ramp_en/|read high in any cycle.

Decomposition:
- PixelSensorConfig package gets: ctrl_state_t enum, default C_ERASE/C_CONVERT/C_READ_ROW constants, ROW_IDX_BITS.
- One sub-module: pixel_row_sequencer (READ phase: row pointer, per-row timer, valid/ready handshake, last-row flag); top FSM owns phases and ramp counter.

Test Plan:
- HEIGHT=2, C_ERASE=5, C_CONVERT=255, C_READ_ROW=5, expose_cycles=10, row_ready=1, start pulse at cycle 0 -> erase cycles 1-5, GAP 6, expose 7-16, GAP 17, ramp_en 18-272 with counter 0..254, GAP 273, read=01 274-279 with row_valid at 279, read=10 280-285 with row_valid at 285, frame_done at 286, busy=0 at 287.
- Same, row_ready held low 3 cycles after first row_valid -> read=01 and row_valid held 3 extra cycles, all later events delayed 3 cycles.
- continuous=1 -> erase rises 2 cycles after frame_done; expose_cycles changed mid-frame takes effect only next frame.
- abort asserted during CONVERT at counter=100 -> next cycle IDLE, counter=0, ramp_en=0, no frame_done; new start accepted.
- reset low during READ row 1 -> all outputs 0 asynchronously; after release, start=1 -> frame restarts at ERASE.
- expose_cycles=0 -> exactly 1 expose cycle; start during EXPOSE ignored (frame timing unchanged).

Source files
------------

// File: rtl/pixel_sensor_ctrl_pkg.sv
// Shared configuration, FSM state encoding and helpers for the pixel sensor frame sequencer.
package pixel_sensor_ctrl_pkg;

  localparam int unsigned PIXEL_ARRAY_HEIGHT = 4;
  localparam int unsigned PIXEL_BITS         = 8;

  localparam int unsigned C_ERASE_DEFAULT    = 5;
  localparam int unsigned C_CONVERT_DEFAULT  = 255;
  localparam int unsigned C_READ_ROW_DEFAULT = 5;

  localparam int unsigned ROW_IDX_BITS =
      (PIXEL_ARRAY_HEIGHT > 1) ? $clog2(PIXEL_ARRAY_HEIGHT) : 1;

  // Plain vector with named constants so legacy code can compare raw state values.
  typedef logic [2:0] ctrl_state_t;

  localparam ctrl_state_t StIdle    = 3'd0;
  localparam ctrl_state_t StErase   = 3'd1;
  localparam ctrl_state_t StGap     = 3'd2;
  localparam ctrl_state_t StExpose  = 3'd3;
  localparam ctrl_state_t StConvert = 3'd4;
  localparam ctrl_state_t StRead    = 3'd5;

  // Row index width; a single-row array still gets a 1-bit index.
  function automatic int unsigned row_idx_bits(input int unsigned h);
    return (h > 1) ? $clog2(h) : 1;
  endfunction

  // An exposure length of zero would stall the FSM, so it is promoted to one cycle.
  function automatic logic [7:0] expose_len(input logic [7:0] cycles);
    return (cycles == 8'd0) ? 8'd1 : cycles;
  endfunction

endpackage

// File: rtl/pixel_sensor_ctrl_if.sv
// Row readout stream: valid/ready handshake with row index and end-of-frame pulse.
interface pixel_sensor_ctrl_if
  import pixel_sensor_ctrl_pkg::*;
#(
  parameter int unsigned IDX_W = ROW_IDX_BITS
) ();

  logic             row_valid;
  logic             row_ready;
  logic [IDX_W-1:0] row_index;
  logic             frame_done;

  modport master (
    output row_valid,
    output row_index,
    output frame_done,
    input  row_ready
  );

  modport slave (
    input  row_valid,
    input  row_index,
    input  frame_done,
    output row_ready
  );

endinterface

// File: rtl/pixel_row_sequencer.sv
// READ phase engine: walks the one-hot row select, times each row, then offers the row on the
// valid/ready stream and pulses frame_done once the last row is accepted.
module pixel_row_sequencer
  import pixel_sensor_ctrl_pkg::*;
#(
  parameter int unsigned HEIGHT     = PIXEL_ARRAY_HEIGHT,
  parameter int unsigned C_READ_ROW = C_READ_ROW_DEFAULT
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                begin_rows,
  input  logic                abort,
  output logic [HEIGHT-1:0]   read,
  pixel_sensor_ctrl_if.master rd
);

  localparam int unsigned IDX_W = row_idx_bits(HEIGHT);

  logic              active_q, active_d;
  logic              valid_q, valid_d;
  logic              done_q, done_d;
  logic [HEIGHT-1:0] read_q, read_d;
  logic [IDX_W-1:0]  row_q, row_d;
  logic [31:0]       timer_q, timer_d;
  logic              last_row;

  assign last_row = (row_q == IDX_W'(HEIGHT - 1));

  // Next-state for row pointer, per-row timer and handshake; abort beats everything.
  always_comb begin
    active_d = active_q;
    valid_d  = valid_q;
    done_d   = 1'b0;
    read_d   = read_q;
    row_d    = row_q;
    timer_d  = timer_q;
    if (abort) begin
      active_d = 1'b0;
      valid_d  = 1'b0;
      read_d   = '0;
      row_d    = '0;
      timer_d  = '0;
    end else if (begin_rows) begin
      active_d = 1'b1;
      valid_d  = 1'b0;
      read_d   = HEIGHT'(1);
      row_d    = '0;
      timer_d  = '0;
    end else if (active_q) begin
      if (!valid_q) begin
        // row_ready is ignored until the row has settled for C_READ_ROW cycles
        if (timer_q == C_READ_ROW - 1) begin
          valid_d = 1'b1;
        end else begin
          timer_d = timer_q + 32'd1;
        end
      end else if (rd.row_ready) begin
        valid_d = 1'b0;
        timer_d = '0;
        if (last_row) begin
          active_d = 1'b0;
          read_d   = '0;
          row_d    = '0;
          done_d   = 1'b1;
        end else begin
          // Advance straight to the next row so READ never drops between rows.
          read_d = read_q << 1;
          row_d  = row_q + IDX_W'(1);
        end
      end
    end
  end

  // Row sequencer state registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      active_q <= 1'b0;
      valid_q  <= 1'b0;
      done_q   <= 1'b0;
      read_q   <= '0;
      row_q    <= '0;
      timer_q  <= '0;
    end else begin
      active_q <= active_d;
      valid_q  <= valid_d;
      done_q   <= done_d;
      read_q   <= read_d;
      row_q    <= row_d;
      timer_q  <= timer_d;
    end
  end

  assign read          = read_q;
  assign rd.row_valid  = valid_q;
  assign rd.row_index  = row_q;
  assign rd.frame_done = done_q;

endmodule

// File: rtl/pixel_sensor_ctrl.sv
// Frame sequencer for the pixel array: ERASE, EXPOSE, CONVERT and READ phases separated by a
// one-cycle GAP, driving the ADC ramp counter and analog enables. All outputs are registered.
module pixel_sensor_ctrl
  import pixel_sensor_ctrl_pkg::*;
#(
  parameter int unsigned HEIGHT     = PIXEL_ARRAY_HEIGHT,
  parameter int unsigned BITS       = PIXEL_BITS,
  parameter int unsigned C_ERASE    = C_ERASE_DEFAULT,
  parameter int unsigned C_CONVERT  = C_CONVERT_DEFAULT,
  parameter int unsigned C_READ_ROW = C_READ_ROW_DEFAULT
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                continuous,
  input  logic                abort,
  input  logic [7:0]          expose_cycles,
  output logic                erase,
  output logic                expose,
  output logic                bias_en,
  output logic                ramp_en,
  output logic [BITS-1:0]     counter,
  output logic [HEIGHT-1:0]   read,
  output logic                busy,
  pixel_sensor_ctrl_if.master rd
);

  ctrl_state_t     state_q, state_d;
  ctrl_state_t     gap_next_q, gap_next_d;
  logic [31:0]     cnt_q, cnt_d;
  logic [7:0]      exp_len_q, exp_len_d;
  logic [BITS-1:0] counter_q, counter_d;
  logic            erase_q, expose_q, ramp_q, busy_q;
  logic            begin_rows;

  // Phase FSM: each timed phase exits through GAP, which then enters gap_next.
  always_comb begin
    state_d    = state_q;
    gap_next_d = gap_next_q;
    cnt_d      = cnt_q;
    exp_len_d  = exp_len_q;
    begin_rows = 1'b0;
    if (abort) begin
      state_d    = StIdle;
      gap_next_d = StIdle;
      cnt_d      = '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            state_d   = StErase;
            cnt_d     = '0;
            exp_len_d = expose_len(expose_cycles);
          end
        end
        StErase: begin
          if (cnt_q == C_ERASE - 1) begin
            state_d    = StGap;
            gap_next_d = StExpose;
            cnt_d      = '0;
          end else begin
            cnt_d = cnt_q + 32'd1;
          end
        end
        StGap: begin
          state_d = gap_next_q;
          cnt_d   = '0;
          // Continuous frames pick up a fresh exposure length here.
          if (gap_next_q == StErase) begin
            exp_len_d = expose_len(expose_cycles);
          end
          if (gap_next_q == StRead) begin
            begin_rows = 1'b1;
          end
        end
        StExpose: begin
          if (cnt_q == {24'd0, exp_len_q} - 32'd1) begin
            state_d    = StGap;
            gap_next_d = StConvert;
            cnt_d      = '0;
          end else begin
            cnt_d = cnt_q + 32'd1;
          end
        end
        StConvert: begin
          if (counter_q == BITS'(C_CONVERT - 1)) begin
            state_d    = StGap;
            gap_next_d = StRead;
          end
        end
        StRead: begin
          // Stay one extra cycle while frame_done is out; continuous is sampled then.
          if (rd.frame_done) begin
            if (continuous) begin
              state_d    = StGap;
              gap_next_d = StErase;
            end else begin
              state_d = StIdle;
            end
          end
        end
        default: begin
          state_d = StIdle;
        end
      endcase
    end
  end

  // Output next-values come from the next state so every strobe is a flop.
  always_comb begin
    counter_d = '0;
    if (state_d == StConvert && state_q == StConvert) begin
      counter_d = counter_q + BITS'(1);
    end
  end

  // Phase state and registered strobes.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= StIdle;
      gap_next_q <= StIdle;
      cnt_q      <= '0;
      exp_len_q  <= 8'd1;
      counter_q  <= '0;
      erase_q    <= 1'b0;
      expose_q   <= 1'b0;
      ramp_q     <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      gap_next_q <= gap_next_d;
      cnt_q      <= cnt_d;
      exp_len_q  <= exp_len_d;
      counter_q  <= counter_d;
      erase_q    <= (state_d == StErase);
      expose_q   <= (state_d == StExpose);
      ramp_q     <= (state_d == StConvert);
      busy_q     <= (state_d != StIdle);
    end
  end

  pixel_row_sequencer #(
    .HEIGHT     (HEIGHT),
    .C_READ_ROW (C_READ_ROW)
  ) u_rows (
    .clk        (clk),
    .reset      (reset),
    .begin_rows (begin_rows),
    .abort      (abort),
    .read       (read),
    .rd         (rd)
  );

  assign erase   = erase_q;
  assign expose  = expose_q;
  assign bias_en = expose_q;
  assign ramp_en = ramp_q;
  assign counter = counter_q;
  assign busy    = busy_q;

endmodule

// File: tb/tb_pixel_sensor_ctrl.sv
// Scoreboard bench: stimulus pushes expected timed events, a negedge monitor pops and compares.
module tb_pixel_sensor_ctrl;

  localparam int H          = 2;
  localparam int C_ERASE    = 5;
  localparam int C_CONVERT  = 255;
  localparam int C_READ_ROW = 5;

  localparam int EV_ERASE_RISE  = 0;
  localparam int EV_ERASE_FALL  = 1;
  localparam int EV_EXPOSE_RISE = 2;
  localparam int EV_EXPOSE_FALL = 3;
  localparam int EV_RAMP_RISE   = 4;
  localparam int EV_RAMP_FALL   = 5;
  localparam int EV_ROW_VALID   = 6;
  localparam int EV_ROW_HS      = 7;
  localparam int EV_DONE        = 8;
  localparam int EV_IDLE        = 9;

  typedef struct {
    int kind;
    int cyc;
    int data;
  } ev_t;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic         continuous = 1'b0;
  logic         abort = 1'b0;
  logic [7:0]   expose_cycles = 8'd10;
  logic         erase, expose, bias_en, ramp_en, busy;
  logic [7:0]   counter;
  logic [H-1:0] read;

  int  cyc = 0;
  int  checks = 0;
  int  failures = 0;
  ev_t exp_q[$];

  pixel_sensor_ctrl_if #(.IDX_W(1)) rd_if ();

  pixel_sensor_ctrl #(
    .HEIGHT     (H),
    .BITS       (8),
    .C_ERASE    (C_ERASE),
    .C_CONVERT  (C_CONVERT),
    .C_READ_ROW (C_READ_ROW)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .continuous    (continuous),
    .abort         (abort),
    .expose_cycles (expose_cycles),
    .erase         (erase),
    .expose        (expose),
    .bias_en       (bias_en),
    .ramp_en       (ramp_en),
    .counter       (counter),
    .read          (read),
    .busy          (busy),
    .rd            (rd_if)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic string ev_name(input int k);
    case (k)
      EV_ERASE_RISE:  return "erase_rise";
      EV_ERASE_FALL:  return "erase_fall";
      EV_EXPOSE_RISE: return "expose_rise";
      EV_EXPOSE_FALL: return "expose_fall";
      EV_RAMP_RISE:   return "ramp_rise";
      EV_RAMP_FALL:   return "ramp_fall";
      EV_ROW_VALID:   return "row_valid";
      EV_ROW_HS:      return "row_handshake";
      EV_DONE:        return "frame_done";
      EV_IDLE:        return "busy_fall";
      default:        return "unknown";
    endcase
  endfunction

  task automatic check(input string name, input int act, input int exp_v);
    checks++;
    if (act != exp_v) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp_v, cyc);
    end
  endtask

  function automatic void push(input int k, input int c, input int d);
    ev_t e;
    e.kind = k;
    e.cyc  = c;
    e.data = d;
    exp_q.push_back(e);
  endfunction

  // Expected event timeline of one frame whose start is sampled in cycle t0.
  function automatic void push_frame(input int t0, input int exp_len, input int stall0,
                                     input int n_rows, output int t_end);
    int t;
    int tv;
    int th;
    int dv;
    t = t0 + 1;          push(EV_ERASE_RISE, t, 0);
    t = t + C_ERASE;     push(EV_ERASE_FALL, t, 0);
    t = t + 1;           push(EV_EXPOSE_RISE, t, 0);
    t = t + exp_len;     push(EV_EXPOSE_FALL, t, 0);
    t = t + 1;           push(EV_RAMP_RISE, t, 0);
    t = t + C_CONVERT;   push(EV_RAMP_FALL, t, C_CONVERT - 1);
    t = t + 1;
    for (int r = 0; r < n_rows; r++) begin
      tv = t + C_READ_ROW;
      dv = (r << 8) | (1 << r);
      push(EV_ROW_VALID, tv, dv);
      th = tv + ((r == 0) ? stall0 : 0);
      push(EV_ROW_HS, th, dv);
      t = th + 1;
    end
    if (n_rows == H) push(EV_DONE, t, 0);
    t_end = t;
  endfunction

  task automatic got(input int kind, input int data);
    ev_t e;
    checks++;
    if (exp_q.size() == 0) begin
      failures++;
      $display("FAIL event: got %s at cycle %0d data %0d, expected none", ev_name(kind), cyc,
               data);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != kind || e.cyc != cyc || e.data != data) begin
        failures++;
        $display("FAIL event: got %s at cycle %0d data %0d, expected %s at cycle %0d data %0d",
                 ev_name(kind), cyc, data, ev_name(e.kind), e.cyc, e.data);
      end
    end
  endtask

  // Monitor: edge-detect DUT outputs at negedge and compare against the scoreboard.
  logic p_erase = 1'b0, p_expose = 1'b0, p_ramp = 1'b0, p_valid = 1'b0, p_busy = 1'b0;
  int   p_counter = 0;
  initial begin
    forever begin
      @(negedge clk);
      if (erase && !p_erase)   got(EV_ERASE_RISE, 0);
      if (!erase && p_erase)   got(EV_ERASE_FALL, 0);
      if (expose && !p_expose) got(EV_EXPOSE_RISE, 0);
      if (!expose && p_expose) got(EV_EXPOSE_FALL, 0);
      if (ramp_en && !p_ramp)  got(EV_RAMP_RISE, int'(counter));
      if (!ramp_en && p_ramp)  got(EV_RAMP_FALL, p_counter);
      if (rd_if.row_valid && !p_valid)
        got(EV_ROW_VALID, (int'(rd_if.row_index) << 8) | int'(read));
      if (rd_if.row_valid && rd_if.row_ready)
        got(EV_ROW_HS, (int'(rd_if.row_index) << 8) | int'(read));
      if (rd_if.frame_done)    got(EV_DONE, int'(read));
      if (!busy && p_busy)     got(EV_IDLE, 0);
      check("strobe_onehot", int'($countones({erase, expose, ramp_en, |read}) <= 1), 1);
      check("bias_eq_expose", int'(bias_en), int'(expose));
      if (!ramp_en) check("counter_idle", int'(counter), 0);
      else if (p_ramp) check("counter_step", int'(counter), p_counter + 1);
      p_erase   = erase;
      p_expose  = expose;
      p_ramp    = ramp_en;
      p_valid   = rd_if.row_valid;
      p_busy    = busy;
      p_counter = int'(counter);
    end
  end

  task automatic wait_until(input int t);
    while (cyc < t) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic start_at(output int t0);
    @(posedge clk);
    #1;
    t0    = cyc;
    start = 1'b1;
  endtask

  task automatic end_start();
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic finish_test(input string name);
    int n;
    n = 0;
    while (busy && n < 2000) begin
      @(posedge clk);
      #1;
      n++;
    end
    check({name, "_idle"}, int'(busy), 0);
    repeat (3) @(posedge clk);
    #1;
    check({name, "_drained"}, exp_q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int t0;
    int td;
    int td2;
    rd_if.row_ready = 1'b1;
    #2 reset = 1'b0;
    #20;
    check("rst_strobes", int'({erase, expose, bias_en, ramp_en}), 0);
    check("rst_counter", int'(counter), 0);
    check("rst_read", int'(read), 0);
    check("rst_stream", int'({rd_if.row_valid, rd_if.row_index, rd_if.frame_done}), 0);
    check("rst_busy", int'(busy), 0);
    @(posedge clk);
    #1 reset = 1'b1;
    repeat (2) @(posedge clk);

    // Basic frame, consumer always ready.
    expose_cycles = 8'd10;
    start_at(t0);
    push_frame(t0, 10, 0, H, td);
    push(EV_IDLE, td + 1, 0);
    end_start();
    finish_test("basic");

    // Consumer stalls the first row for 3 cycles.
    rd_if.row_ready = 1'b0;
    start_at(t0);
    push_frame(t0, 10, 3, H, td);
    push(EV_IDLE, td + 1, 0);
    end_start();
    wait_until(t0 + 279 + 3);
    rd_if.row_ready = 1'b1;
    finish_test("stall");

    // Continuous mode; exposure change mid-frame applies to the next frame only.
    continuous = 1'b1;
    start_at(t0);
    push_frame(t0, 10, 0, H, td);
    push_frame(td + 1, 3, 0, H, td2);
    push(EV_IDLE, td2 + 1, 0);
    end_start();
    wait_until(t0 + 10);
    expose_cycles = 8'd3;
    wait_until(td + 1);
    continuous = 1'b0;
    finish_test("continuous");
    expose_cycles = 8'd10;

    // Abort during CONVERT at counter 100.
    start_at(t0);
    push(EV_ERASE_RISE, t0 + 1, 0);
    push(EV_ERASE_FALL, t0 + 6, 0);
    push(EV_EXPOSE_RISE, t0 + 7, 0);
    push(EV_EXPOSE_FALL, t0 + 17, 0);
    push(EV_RAMP_RISE, t0 + 18, 0);
    push(EV_RAMP_FALL, t0 + 119, 100);
    push(EV_IDLE, t0 + 119, 0);
    end_start();
    wait_until(t0 + 118);
    check("abort_counter_at", int'(counter), 100);
    abort = 1'b1;
    @(posedge clk);
    #1 abort = 1'b0;
    check("abort_counter", int'(counter), 0);
    check("abort_ramp", int'(ramp_en), 0);
    check("abort_busy", int'(busy), 0);
    check("abort_no_done", int'(rd_if.frame_done), 0);
    finish_test("abort");

    // Zero exposure becomes one cycle; start during EXPOSE is ignored.
    expose_cycles = 8'd0;
    start_at(t0);
    push_frame(t0, 1, 0, H, td);
    push(EV_IDLE, td + 1, 0);
    end_start();
    wait_until(t0 + 7);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    finish_test("expose0");
    expose_cycles = 8'd10;

    // Reset asserted while row 1 is being read, then a fresh frame.
    start_at(t0);
    push_frame(t0, 10, 0, 1, td);
    push(EV_IDLE, td, 0);
    end_start();
    wait_until(td);
    check("rstmid_read_row1", int'(read), 2);
    reset = 1'b0;
    #1;
    check("rstmid_outs", int'({erase, expose, bias_en, ramp_en, counter, read, busy}), 0);
    check("rstmid_stream", int'({rd_if.row_valid, rd_if.row_index, rd_if.frame_done}), 0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    start_at(t0);
    push_frame(t0, 10, 0, H, td);
    push(EV_IDLE, td + 1, 0);
    end_start();
    finish_test("restart");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
